// File: rtl/ova_tile_split.sv
// rtl/ova_tile_split.sv - overlap tile splitter: one frame in, num_block_root^2 overlapping tiles out
//
// Captures an inputsize x inputsize frame of 32-bit words and emits it as a
// raster-ordered grid of size x size tiles with stride (size - overlap).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   frame_in     input frame, sampled when frame_valid && frame_ready
//   frame_valid  frame_in is valid
//   frame_ready  a frame can be accepted this cycle
//   tile_out     current tile window of the captured frame
//   tile_valid   tile_out / tile_index / tile_last are valid
//   tile_ready   downstream accepts the current tile
//   tile_index   raster index of the current tile
//   tile_last    current tile is the final tile of the frame
module ova_tile_split #(
  parameter int num_block_root = 4,
  parameter int size           = 4,
  parameter int overlap        = 1,
  localparam int inputsize     = num_block_root * size - (num_block_root - 1) * overlap,
  localparam int num_tiles     = num_block_root * num_block_root,
  localparam int idx_w         = (num_tiles > 1) ? $clog2(num_tiles) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      frame_in [0:inputsize-1][0:inputsize-1],
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic [31:0]      tile_out [0:size-1][0:size-1],
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [idx_w-1:0] tile_index,
  output logic             tile_last
);

  localparam int stride = size - overlap;
  localparam int pos_w  = (inputsize > 1) ? $clog2(inputsize) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(num_tiles - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [idx_w-1:0] cnt;
  logic [31:0]      frame_buf [0:inputsize-1][0:inputsize-1];

  logic emit;
  logic accept;
  int   row;
  int   col;

  assign emit       = (state == EMIT);
  assign tile_valid = emit;
  assign tile_last  = emit && (cnt == last_idx);
  assign tile_index = emit ? cnt : '0;

  // Ready in IDLE, or on the last-tile handshake so frames can run back-to-back.
  // The reset term keeps ready low while the block is held in reset.
  assign frame_ready = reset && (!emit || (tile_last && tile_ready));
  assign accept      = frame_valid && frame_ready;

  // Window select from registers only. cnt is 0 whenever the block is idle,
  // so IDLE naturally shows the tile-0 window.
  always_comb begin
    row = int'(cnt) / num_block_root;
    col = int'(cnt) % num_block_root;
    for (int a = 0; a < size; a++) begin
      for (int b = 0; b < size; b++) begin
        tile_out[a][b] = frame_buf[pos_w'(row * stride + a)][pos_w'(col * stride + b)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int r = 0; r < inputsize; r++) begin
        for (int c = 0; c < inputsize; c++) begin
          frame_buf[r][c] <= '0;
        end
      end
    end else if (accept) begin
      // Covers both the IDLE start and the back-to-back reload on the last tile.
      frame_buf <= frame_in;
      cnt       <= '0;
      state     <= EMIT;
    end else if (emit && tile_ready) begin
      if (cnt == last_idx) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt + idx_w'(1);
      end
    end
  end

endmodule

// File: tb/tb_ova_tile_split.sv
// tb/tb_ova_tile_split.sv - randomized self-checking bench for ova_tile_split
module tb_ova_tile_split;

  localparam int NBR = 4;
  localparam int SZ  = 4;
  localparam int ST  = 3;
  localparam int ISZ = 13;
  localparam int NT  = 16;

  logic        clk;
  logic        reset;
  logic [31:0] frame_in [0:ISZ-1][0:ISZ-1];
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] tile_out [0:SZ-1][0:SZ-1];
  logic        tile_valid;
  logic        tile_ready;
  logic [3:0]  tile_index;
  logic        tile_last;

  logic [31:0] f1_in [0:2][0:2];
  logic        f1_valid;
  logic        f1_ready;
  logic [31:0] t1_out [0:2][0:2];
  logic        t1_valid;
  logic        t1_ready;
  logic [0:0]  t1_index;
  logic        t1_last;

  // Reference model: captured frame plus the list of tiles still owed.
  logic [31:0] mbuf [0:ISZ-1][0:ISZ-1];
  int          q_idx[$];

  int n_checks;
  int n_fail;

  ova_tile_split dut (
    .clk(clk), .reset(reset),
    .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .tile_out(tile_out), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_index(tile_index), .tile_last(tile_last)
  );

  ova_tile_split #(.num_block_root(1), .size(3), .overlap(0)) dut1 (
    .clk(clk), .reset(reset),
    .frame_in(f1_in), .frame_valid(f1_valid), .frame_ready(f1_ready),
    .tile_out(t1_out), .tile_valid(t1_valid), .tile_ready(t1_ready),
    .tile_index(t1_index), .tile_last(t1_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_frame(input int mode, input logic [31:0] val);
    for (int r = 0; r < ISZ; r++)
      for (int c = 0; c < ISZ; c++)
        case (mode)
          0:       frame_in[r][c] = 32'(r * 16 + c);
          1:       frame_in[r][c] = val;
          default: frame_in[r][c] = $urandom;
        endcase
  endtask

  task automatic clear_model();
    q_idx.delete();
    for (int r = 0; r < ISZ; r++)
      for (int c = 0; c < ISZ; c++)
        mbuf[r][c] = '0;
  endtask

  // Called at a negedge with this cycle's inputs already driven: compares
  // the DUT against the model, then advances the model across the posedge.
  task automatic tick();
    logic        m_ready;
    logic        busy;
    int          idx;
    int          r;
    int          c;
    logic [31:0] gw;
    logic [31:0] ew;
    #1;
    busy    = (q_idx.size() > 0);
    m_ready = reset && (!busy || (q_idx.size() == 1 && tile_ready));
    idx     = busy ? q_idx[0] : 0;
    check("frame_ready", 64'(frame_ready), 64'(m_ready));
    check("tile_valid", 64'(tile_valid), 64'(busy));
    check("tile_index", 64'(tile_index), 64'(idx));
    check("tile_last", 64'(tile_last), 64'(busy && idx == NT - 1));
    r  = idx / NBR;
    c  = idx % NBR;
    gw = '0;
    ew = '0;
    for (int a = SZ - 1; a >= 0; a--)
      for (int b = SZ - 1; b >= 0; b--)
        if (tile_out[a][b] !== mbuf[r * ST + a][c * ST + b]) begin
          gw = tile_out[a][b];
          ew = mbuf[r * ST + a][c * ST + b];
        end
    check("tile_out", 64'(gw), 64'(ew));
    @(posedge clk);
    if (reset) begin
      if (busy && tile_ready) void'(q_idx.pop_front());
      if (frame_valid && m_ready) begin
        mbuf = frame_in;
        for (int i = 0; i < NT; i++) q_idx.push_back(i);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int  hold;
    int  idx;
    bit  b2b;
    int  guard;
    logic [31:0] gw;
    logic [31:0] ew;

    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    frame_valid = 1'b0;
    tile_ready  = 1'b0;
    f1_valid    = 1'b0;
    t1_ready    = 1'b0;
    fill_frame(1, 32'h0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        f1_in[r][c] = '0;
    clear_model();

    // Reset state
    @(negedge clk);
    tick();
    check("d1_rst_valid", 64'(t1_valid), 64'(0));
    check("d1_rst_ready", 64'(f1_ready), 64'(0));
    tick();
    reset = 1'b1;
    tick();

    // Ramp frame, tile_ready held high
    fill_frame(0, 0);
    frame_valid = 1'b1;
    tile_ready  = 1'b1;
    tick();
    frame_valid = 1'b0;
    for (int k = 0; k < NT; k++) begin
      if (k == 0) begin
        check("t0_00", 64'(tile_out[0][0]), 64'(0));
        check("t0_33", 64'(tile_out[3][3]), 64'(51));
      end
      if (k == 1) check("t1_00", 64'(tile_out[0][0]), 64'(3));
      if (k == 5) check("t5_00", 64'(tile_out[0][0]), 64'(51));
      if (k == 15) begin
        check("t15_00", 64'(tile_out[0][0]), 64'(153));
        check("t15_33", 64'(tile_out[3][3]), 64'(204));
        check("t15_last", 64'(tile_last), 64'(1));
      end
      tick();
    end
    check("idle_after", 64'(tile_valid), 64'(0));
    tick();

    // Backpressure on tile 2, ignored frames on tiles 3-10, back-to-back on tile 15
    fill_frame(2, 0);
    frame_valid = 1'b1;
    tick();
    hold = 0;
    b2b  = 1'b0;
    for (int cyc = 0; cyc < 60 && !b2b; cyc++) begin
      idx         = (q_idx.size() > 0) ? q_idx[0] : -1;
      tile_ready  = 1'b1;
      frame_valid = 1'b0;
      if (idx == 2 && hold < 2) begin
        tile_ready = 1'b0;
        hold++;
      end
      if (idx >= 3 && idx <= 10) begin
        fill_frame(2, 0);
        frame_valid = 1'b1;
      end
      if (idx == 15) begin
        fill_frame(1, 32'hA5A5A5A5);
        frame_valid = 1'b1;
      end
      tick();
      if (idx == 15) b2b = 1'b1;
    end
    check("b2b_reached", 64'(b2b), 64'(1));
    check("b2b_valid", 64'(tile_valid), 64'(1));
    check("b2b_index", 64'(tile_index), 64'(0));
    check("b2b_word", 64'(tile_out[2][1]), 64'(32'hA5A5A5A5));
    frame_valid = 1'b0;
    tile_ready  = 1'b1;
    for (int k = 0; k < NT + 2; k++) tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      frame_valid = ($urandom_range(0, 2) == 0);
      if (frame_valid) fill_frame(2, 0);
      tile_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset in the middle of tile 7
    frame_valid = 1'b0;
    tile_ready  = 1'b1;
    for (int k = 0; k < NT + 2; k++) tick();
    fill_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    guard = 0;
    while ((q_idx.size() == 0 || q_idx[0] != 7) && guard < 40) begin
      tick();
      guard++;
    end
    check("reach_tile7", 64'(tile_index), 64'(7));
    #3;
    reset = 1'b0;
    #1;
    check("rst_valid", 64'(tile_valid), 64'(0));
    check("rst_word", 64'(tile_out[1][1]), 64'(0));
    check("rst_ready", 64'(frame_ready), 64'(0));
    clear_model();
    @(negedge clk);
    tick();
    reset = 1'b1;
    tick();
    fill_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    check("restart_index", 64'(tile_index), 64'(0));
    check("restart_33", 64'(tile_out[3][3]), 64'(51));
    for (int k = 0; k < NT + 1; k++) tick();

    // Single-tile configuration: tile equals the whole frame
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        f1_in[r][c] = $urandom;
    f1_valid = 1'b1;
    t1_ready = 1'b1;
    #1;
    check("d1_ready", 64'(f1_ready), 64'(1));
    tick();
    f1_valid = 1'b0;
    check("d1_valid", 64'(t1_valid), 64'(1));
    check("d1_last", 64'(t1_last), 64'(1));
    check("d1_index", 64'(t1_index), 64'(0));
    gw = '0;
    ew = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (t1_out[r][c] !== f1_in[r][c]) begin
          gw = t1_out[r][c];
          ew = f1_in[r][c];
        end
    check("d1_tile", 64'(gw), 64'(ew));
    tick();
    check("d1_idle_valid", 64'(t1_valid), 64'(0));
    check("d1_idle_last", 64'(t1_last), 64'(0));
    check("d1_idle_ready", 64'(f1_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ova_tile_split.md
# ova_tile_split

Overlap tile splitter: the read-side counterpart of the overlap-add accumulator. It captures one full `inputsize x inputsize` frame of 32-bit words and emits it as `num_block_root^2` overlapping `size x size` tiles, one tile per handshake. Tiles are emitted in raster order over a grid with stride `size-overlap`. It feeds per-tile processing (convolution/transform) whose results are later recombined by overlap-add.

## Interface
- `num_block_root`, 4, tiles per row/column of the grid (≥1)
- `size`, 4, tile edge length in words
- `overlap`, 1, words shared by adjacent tiles; 0 ≤ overlap < size
- `inputsize`, derived = num_block_root*size − (num_block_root−1)*overlap (13 at defaults); not overridable
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `frame_in`  in  [31:0] x [0:inputsize-1][0:inputsize-1]  input frame, sampled on accept
- `frame_valid`  in  1  frame_in is valid
- `frame_ready`  out  1  block can accept a frame this cycle
- `tile_out`  out  [31:0] x [0:size-1][0:size-1]  current tile
- `tile_valid`  out  1  tile_out/tile_index/tile_last valid
- `tile_ready`  in  1  downstream accepts tile this cycle
- `tile_index`  out  max(1,$clog2(num_block_root^2))  raster index of current tile
- `tile_last`  out  1  current tile is index num_block_root^2−1

## Operation
- States: IDLE, EMIT. Registers: `frame_buf` (inputsize² words), `cnt` (tile counter), `state`.
- `frame_ready` = (state==IDLE) OR (state==EMIT AND tile_last AND tile_ready); forced 0 while reset is low.
- Frame accept = frame_valid AND frame_ready at a rising edge: frame_buf ← frame_in, cnt ← 0, state ← EMIT.
- In EMIT: tile_valid=1, tile_index=cnt, row=cnt/num_block_root, col=cnt%num_block_root.
  - tile_out[a][b] = frame_buf[row*(size−overlap)+a][col*(size−overlap)+b].
  - tile_out is a function of registers only; no combinational path from frame_in to tile_out.
- Tile handshake = tile_valid AND tile_ready:
  - If not last: cnt ← cnt+1.
  - If last and a frame is accepted in the same cycle: reload frame_buf, cnt ← 0, stay in EMIT (back-to-back).
  - If last and no frame is accepted: cnt ← 0, state ← IDLE.
- tile_valid=1 AND tile_ready=0: tile_out, tile_index, tile_last and frame_buf are held unchanged. tile_valid is never withdrawn before the handshake.
- frame_valid in EMIT, other than on the last-tile handshake cycle: ignored, not consumed. frame_in may change freely.
- In IDLE: tile_valid=0, tile_last=0, tile_index=0; tile_out shows the tile-0 window of frame_buf (don't-care for consumers).
- num_block_root=1: a single tile; tile_last=1 whenever tile_valid=1.
- Arithmetic: pure data movement; no add/modify of words. Index math uses integer widths sized for inputsize.

## Timing
- Reset (reset low, asynchronous): state=IDLE, cnt=0, frame_buf all 0.
  - Outputs during reset: tile_valid=0, tile_last=0, tile_index=0, tile_out all 0, frame_ready=0.
  - frame_ready rises combinationally after reset deasserts.
- Reset asserted mid-frame: remaining tiles are dropped; the block restarts in IDLE with the buffer cleared.
- Frame accepted at edge k: tile 0 is valid in the cycle after edge k (1-cycle latency).
- With tile_ready held high: one tile per cycle, num_block_root² cycles per frame.
- Back-to-back frames: 100% tile throughput with no idle cycle between frames.
- Isolated frame: tile_valid is low for exactly one cycle (the IDLE cycle) before a new frame can start.

## Test plan
- Reset, then frame_in[r][c]=r*16+c, tile_ready=1, default parameters.
  - Tile 0: tile_out[0][0]=0, [3][3]=51. Tile 1: [0][0]=3. Tile 5: [0][0]=51.
  - Tile 15: [0][0]=153, [3][3]=204, tile_last=1.
  - 16 consecutive valid cycles, then IDLE.
- Backpressure: tile_ready toggles 1,0,0,1 during tile 2.
  - tile_index=2 and tile_out hold for 3 cycles; no tile skipped or duplicated.
- Back-to-back: second frame (all words 0xA5A5A5A5) presented with frame_valid high throughout tile 15.
  - Accepted on the tile-15 handshake; the next cycle shows tile_index=0, tile_out all 0xA5A5A5A5.
  - tile_valid never drops.
- frame_valid asserted during tiles 3–10 with a different frame: not accepted (frame_ready=0); tiles still come from the first frame.
- Async reset low at tile 7, mid-cycle: tile_valid drops immediately; tile_out becomes 0.
  - After release: frame_ready=1, and a new frame restarts at tile_index=0.
- num_block_root=1, size=3, overlap=0 (inputsize=3): one tile equal to the whole frame, tile_last=1, return to IDLE.
